// File: rtl/sh7034_ifetch.sv
// SH7034 instruction prefetch queue: fetches longwords over IBUS and feeds
// decode one big-endian halfword at a time. A flush restarts the stream.
module sh7034_ifetch #(
  parameter int QDEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        ce_r_i,
  input  logic        ce_f_i,
  input  logic        flush_i,
  input  logic [27:0] flush_a_i,
  output logic [15:0] instr_o,
  output logic        instr_valid_o,
  input  logic        instr_ack_i,
  output logic [27:0] ibus_a_o,
  input  logic [31:0] ibus_di_i,
  output logic [3:0]  ibus_ba_o,
  output logic        ibus_we_o,
  output logic        ibus_req_o,
  input  logic        ibus_busy_i
);

  // state   | meaning
  // IDLE    | no read outstanding (queue full)
  // REQ     | read of fp_q outstanding; data lands on the next non-busy CE_R
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem_q [QDEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hsel_q, hsel_d;
  logic            skip_q, skip_d;
  logic [27:0]     fp_q, fp_d;
  logic            mem_we;
  logic            ack_ok, pop, push;
  logic [31:0]     head;
  logic            unused_inputs;

  assign unused_inputs = ^{ce_f_i, flush_a_i[0]};

  assign instr_valid_o = (cnt_q != '0);
  assign head          = mem_q[rd_q];
  assign instr_o       = !instr_valid_o ? 16'h0000 :
                         (hsel_q ? head[15:0] : head[31:16]);
  assign ibus_a_o      = fp_q;
  assign ibus_req_o    = (state_q == ST_REQ);
  assign ibus_ba_o     = 4'hF;
  assign ibus_we_o     = 1'b0;

  assign ack_ok = instr_ack_i && instr_valid_o;
  assign pop    = ack_ok && hsel_q;
  assign push   = (state_q == ST_REQ) && !ibus_busy_i;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    hsel_d  = hsel_q;
    skip_d  = skip_q;
    fp_d    = fp_q;
    mem_we  = 1'b0;
    if (ce_r_i) begin
      if (flush_i) begin
        // drop queue and any returning data; refetch starts on this same edge
        rd_d    = '0;
        wr_d    = '0;
        cnt_d   = '0;
        hsel_d  = 1'b0;
        skip_d  = flush_a_i[1];
        fp_d    = {flush_a_i[27:2], 2'b00};
        state_d = ST_REQ;
      end else begin
        if (ack_ok) begin
          hsel_d = ~hsel_q;
          if (hsel_q) rd_d = rd_q + PW'(1);
        end
        if (push) begin
          mem_we = 1'b1;
          wr_d   = wr_q + PW'(1);
          fp_d   = fp_q + 28'd4;
          if (skip_q) begin
            hsel_d = 1'b1;
            skip_d = 1'b0;
          end
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (!((state_q == ST_REQ) && ibus_busy_i))
          state_d = (cnt_d < CW'(QDEPTH)) ? ST_REQ : ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      hsel_q  <= 1'b0;
      skip_q  <= 1'b0;
      fp_q    <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      hsel_q  <= hsel_d;
      skip_q  <= skip_d;
      fp_q    <= fp_d;
      if (mem_we) mem_q[wr_q] <= ibus_di_i;
    end
  end

endmodule

// File: tb/tb_sh7034_ifetch.sv
// Bench for sh7034_ifetch: halfword-stream reference model compared every
// clock, plus directed scenarios with literal expectations.
module tb_sh7034_ifetch;
  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, ce_r, ce_f, flush, ack, busy;
  logic [27:0] flush_a;
  logic [15:0] instr;
  logic        valid, req, we;
  logic [27:0] ibus_a;
  logic [31:0] ibus_di;
  logic [3:0]  ba;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [27:0] a);
    if (a == 28'h0) return 32'h1234_5678;
    if (a == 28'h4) return 32'hABCD_EF01;
    return ({4'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  assign ibus_di = rom(ibus_a);

  sh7034_ifetch #(.QDEPTH(QDEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ce_r_i(ce_r), .ce_f_i(ce_f),
    .flush_i(flush), .flush_a_i(flush_a),
    .instr_o(instr), .instr_valid_o(valid), .instr_ack_i(ack),
    .ibus_a_o(ibus_a), .ibus_di_i(ibus_di), .ibus_ba_o(ba),
    .ibus_we_o(we), .ibus_req_o(req), .ibus_busy_i(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: the queue is a stream of pending instruction halfwords.
  // m_odd means the head halfword is the low half of its longword.
  logic [15:0] m_hq[$];
  bit          m_odd, m_skip, m_req;
  logic [27:0] m_fp;

  task automatic model_reset();
    m_hq.delete();
    m_odd = 0; m_skip = 0; m_req = 0; m_fp = '0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    int lw;
    if (flush) begin
      m_hq.delete();
      m_odd  = 0;
      m_skip = flush_a[1];
      m_fp   = {flush_a[27:2], 2'b00};
      m_req  = 1;
    end else begin
      bit accepted;
      accepted = m_req && !busy;
      if (ack && m_hq.size() > 0) begin
        void'(m_hq.pop_front());
        m_odd = !m_odd;
      end
      if (accepted) begin
        w = rom(m_fp);
        if (m_hq.size() == 0) begin
          if (m_skip) begin
            m_hq.push_back(w[15:0]);
            m_odd = 1;
          end else begin
            m_hq.push_back(w[31:16]);
            m_hq.push_back(w[15:0]);
            m_odd = 0;
          end
        end else begin
          m_hq.push_back(w[31:16]);
          m_hq.push_back(w[15:0]);
        end
        m_skip = 0;
        m_fp   = m_fp + 28'd4;
      end
      lw = (m_hq.size() + int'(m_odd)) / 2;
      if (!(m_req && busy)) m_req = (lw < QDEPTH);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else if (ce_r) model_step();
    #1;
    if (rst_n) begin
      chk("m_addr",  {4'h0, ibus_a}, {4'h0, m_fp});
      chk("m_req",   {31'h0, req},   {31'h0, m_req});
      chk("m_valid", {31'h0, valid}, {31'h0, (m_hq.size() > 0)});
      chk("m_instr", {16'h0, instr}, {16'h0, (m_hq.size() > 0) ? m_hq[0] : 16'h0000});
      chk("m_ba",    {28'h0, ba},    32'hF);
      chk("m_we",    {31'h0, we},    32'h0);
    end
  end

  task automatic reset_hold();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; ce_r = 1'b1; ce_f = 1'b0; flush = 1'b0; flush_a = '0;
    ack = 1'b1; busy = 1'b0;

    // zero-wait stream with ACK every cycle
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'h0, req},   0);
    chk("rst_addr",  {4'h0, ibus_a}, 0);
    chk("rst_valid", {31'h0, valid}, 0);
    chk("rst_instr", {16'h0, instr}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s1_req",   {31'h0, req},   1);
    chk("s1_addr0", {4'h0, ibus_a}, 0);
    chk("s1_nv",    {31'h0, valid}, 0);
    @(negedge clk);
    chk("s1_valid", {31'h0, valid}, 1);
    chk("s1_i0",    {16'h0, instr}, 32'h1234);
    chk("s1_addr4", {4'h0, ibus_a}, 4);
    @(negedge clk); chk("s1_i1", {16'h0, instr}, 32'h5678);
    @(negedge clk); chk("s1_i2", {16'h0, instr}, 32'hABCD);
    @(negedge clk); chk("s1_i3", {16'h0, instr}, 32'hEF01);

    // ACK held low: queue fills, fetch stops at 8
    reset_hold();
    ack = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("s2_req0",  {31'h0, req},   0);
    chk("s2_addr8", {4'h0, ibus_a}, 8);
    chk("s2_hold",  {16'h0, instr}, 32'h1234);
    ack = 1'b1;
    @(negedge clk);
    chk("s2_still0", {31'h0, req},   0);
    chk("s2_i1",     {16'h0, instr}, 32'h5678);
    @(negedge clk);
    chk("s2_resume", {31'h0, req},   1);
    chk("s2_addr8b", {4'h0, ibus_a}, 8);
    chk("s2_i2",     {16'h0, instr}, 32'hABCD);

    // flush to an odd halfword while a request is outstanding
    reset_hold();
    ack = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    flush = 1'b1; flush_a = 28'h000_0106;
    @(negedge clk);
    flush = 1'b0;
    chk("s3_addr", {4'h0, ibus_a}, 32'h104);
    chk("s3_req",  {31'h0, req},   1);
    chk("s3_nv",   {31'h0, valid}, 0);
    @(negedge clk);
    w = rom(28'h104);
    chk("s3_first", {16'h0, instr}, {16'h0, w[15:0]});
    @(negedge clk);
    w = rom(28'h108);
    chk("s3_second", {16'h0, instr}, {16'h0, w[31:16]});

    // slave wait for three cycles
    reset_hold();
    ack = 1'b0; busy = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s4_addr_hold", {4'h0, ibus_a}, 0);
      chk("s4_req_hold",  {31'h0, req},   1);
      chk("s4_nv",        {31'h0, valid}, 0);
    end
    busy = 1'b0;
    @(negedge clk);
    chk("s4_cap",   {16'h0, instr}, 32'h1234);
    chk("s4_addr4", {4'h0, ibus_a}, 4);
    ack = 1'b1;
    @(negedge clk); chk("s4_i1", {16'h0, instr}, 32'h5678);
    @(negedge clk); chk("s4_i2", {16'h0, instr}, 32'hABCD);

    // CE_R on every other clock
    reset_hold();
    ack = 1'b1;
    rst_n = 1'b1;
    @(negedge clk); ce_r = 1'b0;
    @(negedge clk);
    chk("s5_idle_nv",  {31'h0, valid}, 0);
    chk("s5_idle_req", {31'h0, req},   1);
    ce_r = 1'b1;
    @(negedge clk); ce_r = 1'b0;
    chk("s5_i0", {16'h0, instr}, 32'h1234);
    @(negedge clk); ce_r = 1'b1;
    chk("s5_i0_hold", {16'h0, instr}, 32'h1234);
    @(negedge clk);
    chk("s5_i1", {16'h0, instr}, 32'h5678);

    // asynchronous reset in the middle of a stream
    reset_hold();
    ack = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("s6_pre_valid", {31'h0, valid}, 1);
    chk("s6_pre_req",   {31'h0, req},   1);
    rst_n = 1'b0;
    #1;
    chk("s6_async_req",   {31'h0, req},   0);
    chk("s6_async_valid", {31'h0, valid}, 0);
    chk("s6_async_addr",  {4'h0, ibus_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s6_restart_req",  {31'h0, req},   1);
    chk("s6_restart_addr", {4'h0, ibus_a}, 0);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      ce_r  = ($urandom_range(0, 3) != 0);
      ce_f  = $urandom_range(0, 1) == 1;
      ack   = ($urandom_range(0, 9) < 7);
      busy  = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 39) == 0);
      flush_a = 28'($urandom);
      if ($urandom_range(0, 7) == 0) flush_a = 28'hFFF_FFF0 | 28'($urandom_range(0, 15));
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sh7034_ifetch.md
Name: sh7034_ifetch

Overview:
- Instruction-fetch prefetch queue for the SH7034 core. Sits directly upstream of the on-chip ROM and other internal-bus slaves.
- Issues 32-bit read requests on the internal bus (IBUS) and buffers up to two returned longwords.
- Hands the CPU decode stage one 16-bit big-endian instruction at a time via a valid/ack handshake.
- A flush (branch, exception) discards the queue and restarts fetching at a new halfword address.

Parameters:
- QDEPTH, 2, number of 32-bit queue entries (power of two, 2 or 4).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- CE_R  in  1  rising-phase clock enable; all state advances only on CLK edges with CE_R=1
- CE_F  in  1  falling-phase clock enable; unused internally, kept for bus uniformity
- FLUSH  in  1  restart fetch at FLUSH_A (pulse, sampled on CE_R)
- FLUSH_A  in  28  halfword byte address of the new stream; bit 0 ignored
- INSTR  out  16  current instruction
- INSTR_VALID  out  1  INSTR is valid
- INSTR_ACK  in  1  decode consumes INSTR (counts only when INSTR_VALID=1 on a CE_R edge)
- IBUS_A  out  28  longword-aligned read address (bits 1:0 = 0)
- IBUS_DI  in  32  read data from slave
- IBUS_BA  out  4  byte enables, constant 4'hF
- IBUS_WE  out  1  constant 0
- IBUS_REQ  out  1  read request
- IBUS_BUSY  in  1  slave wait; hold request and address while 1

Behaviour:
- Reset (async, RST_N=0) values:
  - IBUS_REQ=0, IBUS_A=0, INSTR_VALID=0, INSTR=0.
  - Queue empty, fetch pointer 0, state IDLE, skip flag 0.
  - After release, fetching starts at address 0.
- Queue state:
  - QDEPTH longword entries plus a halfword select bit HSEL for the head entry.
  - Halfword selection: HSEL=0 → INSTR=head[31:16]; HSEL=1 → INSTR=head[15:0].
  - INSTR_VALID=1 iff the queue is non-empty. INSTR is combinational from the head entry.
- Consume: INSTR_ACK with INSTR_VALID on CE_R:
  - HSEL=0 → HSEL becomes 1.
  - HSEL=1 → pop head, HSEL becomes 0.
- State machine, evaluated on CE_R:
  - IDLE: if free slots exceed in-flight requests (max one in flight), assert IBUS_REQ with IBUS_A = fetch pointer → REQ.
  - REQ: ROM data is valid one CE_R after the request, so on the next CE_R:
    - IBUS_BUSY=0: capture IBUS_DI into the tail entry and advance the fetch pointer by 4 (wraps modulo 2^28). If there is still space after this push, keep IBUS_REQ=1 with the next address (back-to-back, one longword per CE_R); else deassert → IDLE.
    - IBUS_BUSY=1: hold IBUS_A and IBUS_REQ unchanged and stay in REQ.
- Full queue: no request is issued; IBUS_REQ=0.
- Simultaneous pop and push on the same edge when full: allowed; the pop frees the slot that the push fills. Count is unchanged.
- Flush:
  - Clears the queue and sets the fetch pointer to {FLUSH_A[27:2],2'b00}.
  - Sets a skip flag = FLUSH_A[1]; the first captured longword then enters with HSEL=FLUSH_A[1].
  - An in-flight response returning on the flush edge is discarded.
  - Any INSTR_ACK on the flush edge is ignored.
  - INSTR_VALID=0 on the cycle after flush.
  - A new request is issued on the same edge as the flush (IBUS_REQ=1 with the new address).
  - FLUSH during BUSY: the old request is abandoned and the address switches immediately. Slaves must tolerate this; the ROM is combinational-select and does.
- CE_R=0: all outputs and state hold.
- Reset mid-request: aborts immediately with no residual request.
- Throughput target: sustained one instruction per CE_R from zero-wait ROM.

Test Plan:
- Reset then release, ROM word at 0 = 32'h1234_5678, at 4 = 32'hABCD_EF01, BUSY=0, ACK=1 every CE_R → IBUS_A sequence 0,4,8…; INSTR sequence 16'h1234, 16'h5678, 16'hABCD, 16'hEF01 with no gaps after first valid (first valid on 2nd CE_R after reset release).
- ACK held 0 → queue fills QDEPTH longwords, IBUS_REQ drops to 0, IBUS_A stops at 8 (QDEPTH=2); raising ACK resumes fetch at 8 once a slot frees.
- FLUSH with FLUSH_A=28'h000_0106 while a request is in flight → queue emptied, IBUS_A=28'h000_0104 on the same edge, first INSTR = low half of word at 0x104, next = upper half of word at 0x108.
- IBUS_BUSY=1 for 3 CE_R on a request → IBUS_A and IBUS_REQ stable for all 3; data captured only on the first edge with BUSY=0; no duplicate entries.
- CE_R toggled every other CLK → behaviour identical to the first scenario in CE_R cycles; nothing changes on CE_R=0 edges.
- RST_N asserted mid-stream (queue holding 2 entries, REQ=1) → IBUS_REQ=0 and INSTR_VALID=0 asynchronously; after release, fetch restarts at address 0.
